// File: rtl/exc_commit_ctrl.sv
// Writeback-stage exception/ertn commit controller feeding the CSR file and the fetch redirect.
// Optional macro EXC_COMMIT_STATS_EN adds the exc_count/int_count statistics outputs.
module exc_commit_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [4:0]      wb_exc,
  input  logic [XLEN-1:0] wb_badaddr,
  input  logic            wb_ertn,
  input  logic            csr_need_interrupt,
  input  logic [XLEN-1:0] csr_eentry,
  input  logic [XLEN-1:0] csr_era,
  output logic            is_exc,
  output logic            is_ret,
  output logic            addr_exc,
  output logic [5:0]      ecode,
  output logic [8:0]      esubcode,
  output logic [XLEN-1:0] pc_to_era,
  output logic [XLEN-1:0] pc_to_badv,
  output logic            commit_ok,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
`ifdef EXC_COMMIT_STATS_EN
  ,
  output logic [31:0]     exc_count,
  output logic [31:0]     int_count
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_int_q;
  logic              r_redirect_valid;
  logic [XLEN-1:0]   r_redirect_pc;

  logic              w_idle;
  logic              w_take;
  logic              w_ret;
  logic              w_trig;
  logic              w_addr_exc;
  logic [5:0]        w_ecode;
  logic [XLEN-1:0]   w_badv;

  // Strobes are gated by reset so nothing reaches the CSR file during reset.
  assign w_idle = ~reset & (r_state == IDLE);
  assign w_take = w_idle & wb_valid & (r_int_q | (|wb_exc));
  assign w_ret  = w_idle & wb_valid & wb_ertn & ~w_take;
  assign w_trig = w_take | w_ret;

  // Cause priority: INT > ADEF > INE > SYS > BRK > ALE.
  always_comb begin
    w_ecode    = 6'h00;
    w_addr_exc = 1'b0;
    w_badv     = '0;
    if (w_take && !r_int_q) begin
      if (wb_exc[4]) begin
        w_ecode    = 6'h08;
        w_addr_exc = 1'b1;
        w_badv     = wb_pc;
      end else if (wb_exc[3]) begin
        w_ecode = 6'h0D;
      end else if (wb_exc[2]) begin
        w_ecode = 6'h0B;
      end else if (wb_exc[1]) begin
        w_ecode = 6'h0C;
      end else if (wb_exc[0]) begin
        w_ecode    = 6'h09;
        w_addr_exc = 1'b1;
        w_badv     = wb_badaddr;
      end
    end
  end

  assign is_exc         = w_take;
  assign is_ret         = w_ret;
  assign addr_exc       = w_addr_exc;
  assign ecode          = w_ecode;
  assign esubcode       = 9'd0;
  assign pc_to_era      = w_take ? wb_pc : '0;
  assign pc_to_badv     = w_badv;
  assign commit_ok      = w_idle & wb_valid & ~w_take;
  assign flush          = w_trig | (r_state == FLUSH);
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state != IDLE);

  // Target is sampled in the trigger cycle, before the CSR file updates ERA/EENTRY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= 4'd0;
      r_int_q          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_int_q          <= csr_need_interrupt;
      r_redirect_valid <= w_trig;
      if (w_trig) begin
        r_redirect_pc <= w_take ? csr_eentry : csr_era;
      end
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_cnt   <= LP_FLUSH;
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EXC_COMMIT_STATS_EN
  logic [31:0] r_exc_count;
  logic [31:0] r_int_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_count <= 32'd0;
      r_int_count <= 32'd0;
    end else begin
      if (w_take) r_exc_count <= r_exc_count + 32'd1;
      if (w_take && r_int_q) r_int_count <= r_int_count + 32'd1;
    end
  end

  assign exc_count = r_exc_count;
  assign int_count = r_int_count;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Random and directed stimulus for exc_commit_ctrl, checked against a cycle-level behavioural model.
module tb_exc_commit_ctrl;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [4:0]      wb_exc;
  logic [XLEN-1:0] wb_badaddr;
  logic            wb_ertn;
  logic            csr_need_interrupt;
  logic [XLEN-1:0] csr_eentry;
  logic [XLEN-1:0] csr_era;
  logic            is_exc, is_ret, addr_exc, commit_ok, flush, redirect_valid, busy;
  logic [5:0]      ecode;
  logic [8:0]      esubcode;
  logic [XLEN-1:0] pc_to_era, pc_to_badv, redirect_pc;
`ifdef EXC_COMMIT_STATS_EN
  logic [31:0]     exc_count, int_count;
`endif

  exc_commit_ctrl #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_badaddr(wb_badaddr), .wb_ertn(wb_ertn), .csr_need_interrupt(csr_need_interrupt),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .is_exc(is_exc), .is_ret(is_ret),
    .addr_exc(addr_exc), .ecode(ecode), .esubcode(esubcode), .pc_to_era(pc_to_era),
    .pc_to_badv(pc_to_badv), .commit_ok(commit_ok), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
`ifdef EXC_COMMIT_STATS_EN
    , .exc_count(exc_count), .int_count(int_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: pending interrupt sample, remaining flush cycles, redirect register, stats.
  bit          m_int_q;
  int          m_flush_left;
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_exc_cnt, m_int_cnt;

  // Cause table, highest priority first: wb_exc bit index and its ecode.
  int          prio_bit [5] = '{4, 3, 2, 1, 0};
  logic [5:0]  prio_code[5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [31:0] pc, input logic [4:0] exc,
                      input logic [31:0] bad, input bit ertn, input bit cni,
                      input logic [31:0] eentry, input logic [31:0] era);
    bit          busy_e, take, ret, trig;
    int          win;
    logic [5:0]  ec;
    bit          ax;
    logic [31:0] badv;
    @(negedge clk);
    reset = rst; wb_valid = v; wb_pc = pc; wb_exc = exc; wb_badaddr = bad;
    wb_ertn = ertn; csr_need_interrupt = cni; csr_eentry = eentry; csr_era = era;
    #2;
    busy_e = (m_flush_left > 0);
    take   = !rst && !busy_e && v && (m_int_q || exc != 0);
    ret    = !rst && !busy_e && v && ertn && !take;
    trig   = take || ret;
    win = -1;
    if (take && !m_int_q)
      for (int i = 4; i >= 0; i--) if (exc[prio_bit[i]]) win = i;
    ec   = (win >= 0) ? prio_code[win] : 6'h00;
    ax   = (win == 0) || (win == 4);
    badv = (win == 0) ? pc : (win == 4) ? bad : 32'h0;
    chk("is_exc", is_exc, take);
    chk("is_ret", is_ret, ret);
    chk("addr_exc", addr_exc, ax);
    chk("ecode", ecode, ec);
    chk("esubcode", esubcode, 0);
    chk("pc_to_era", pc_to_era, take ? pc : 32'h0);
    chk("pc_to_badv", pc_to_badv, badv);
    chk("commit_ok", commit_ok, !rst && !busy_e && v && !take);
    chk("flush", flush, trig || busy_e);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("busy", busy, busy_e);
`ifdef EXC_COMMIT_STATS_EN
    chk("exc_count", exc_count, m_exc_cnt);
    chk("int_count", int_count, m_int_cnt);
`endif
    @(posedge clk);
    if (rst) begin
      m_int_q = 0; m_flush_left = 0; m_rv = 0; m_rpc = 0; m_exc_cnt = 0; m_int_cnt = 0;
    end else begin
      m_int_q = cni;
      m_rv    = trig;
      if (trig) m_rpc = take ? eentry : era;
      if (take) m_exc_cnt = m_exc_cnt + 1;
      if (take && win < 0) m_int_cnt = m_int_cnt + 1;
      m_flush_left = trig ? FC : (busy_e ? m_flush_left - 1 : 0);
    end
  endtask

  task automatic idle(input int n, input bit cni);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, cni, 32'h1c008000, 32'h1c000404);
  endtask

  initial begin
    reset = 1; wb_valid = 0; wb_pc = 0; wb_exc = 0; wb_badaddr = 0; wb_ertn = 0;
    csr_need_interrupt = 0; csr_eentry = 0; csr_era = 0;
    @(posedge clk);
    m_int_q = 0; m_flush_left = 0; m_rv = 0; m_rpc = 0; m_exc_cnt = 0; m_int_cnt = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    // SYS
    step(0, 1, 32'h1c000100, 5'b00100, 0, 0, 0, 32'h1c008000, 32'h0);
    idle(4, 0);
    // ALE
    step(0, 1, 32'h1c000200, 5'b00001, 32'h00000103, 0, 0, 32'h1c008000, 32'h0);
    idle(4, 0);
    // ADEF|INE|ALE
    step(0, 1, 32'h1c000301, 5'b11001, 32'h00000555, 0, 0, 32'h1c008000, 32'h0);
    idle(4, 0);
    // SYS+BRK
    step(0, 1, 32'h1c000340, 5'b00110, 0, 0, 0, 32'h1c008000, 32'h0);
    idle(4, 0);
    // Interrupt raised while instructions keep flowing
    for (int c = 0; c < 10; c++)
      step(0, 1, 32'h1c000500 + 4 * c, 0, 0, 0, c >= 5, 32'h1c008000, 32'h0);
    idle(4, 0);
    // ertn, then ertn+SYS
    step(0, 1, 32'h1c000400, 0, 0, 1, 0, 32'h1c008000, 32'h1c000404);
    idle(4, 0);
    step(0, 1, 32'h1c000410, 5'b00100, 0, 1, 0, 32'h1c008000, 32'h1c000404);
    idle(4, 0);
    // Reset at T+1 of a flush
    step(0, 1, 32'h1c000600, 5'b00010, 0, 0, 0, 32'h1c008000, 32'h0);
    step(1, 1, 32'h1c000604, 5'b00010, 0, 0, 0, 32'h1c008000, 32'h0);
    idle(3, 0);
    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom,
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
           $urandom,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
